// File: rtl/top_mult_pkg.sv
// Shared types and helpers for the systolic matrix multiplier.
package top_mult_pkg;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DONE
  } state_t;

  function automatic int cnt_width(input int size);
    return $clog2(3 * size);
  endfunction

endpackage

// File: rtl/mult_celula.sv
// One multiply-accumulate cell of the systolic grid; passes operands right/down.
// Define TOP_MULT_SAT_EN to make the accumulator saturate instead of wrapping.
module mult_celula
  import top_mult_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WIDTHx = 5
) (
  input  logic              clock,
  input  logic              nreset,
  input  logic              en,
  input  logic [WIDTHx-1:0] a_in,
  input  logic [WIDTHx-1:0] b_in,
  output logic [WIDTHx-1:0] a_out,
  output logic [WIDTHx-1:0] b_out,
  output logic [WIDTH-1:0]  acc
);

  localparam int PW = 2 * WIDTHx;
  // One spare bit so the saturating compare sees the true sum.
  localparam int SW = ((WIDTH > PW) ? WIDTH : PW) + 1;

  logic [PW-1:0]    prod;
  logic [SW-1:0]    sum;
  logic [WIDTH-1:0] acc_next;

  always_comb begin
    prod = PW'(a_in) * PW'(b_in);
    sum  = SW'(acc) + SW'(prod);
`ifdef TOP_MULT_SAT_EN
    acc_next = (sum > SW'({WIDTH{1'b1}})) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
    acc_next = sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc   <= '0;
      a_out <= '0;
      b_out <= '0;
    end else if (en) begin
      acc   <= acc_next;
      a_out <= a_in;
      b_out <= b_in;
    end
  end

endmodule

// File: rtl/top_mult_celula_sa.sv
// Output-stationary systolic C = A x B: operand latch, skewed feeders, FSM and MAC grid.
// Optional TOP_MULT_SAT_EN selects saturating accumulators (see mult_celula).
module top_mult_celula_sa
  import top_mult_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int WIDTHx = 5,
  parameter int SIZE   = 5
) (
  input  logic                                clock,
  input  logic                                nreset,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] a_input,
  input  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] b_input,
  output logic [SIZE-1:0][SIZE-1:0][WIDTH-1:0]  output_produc_a_b,
  output logic                                done
);

  localparam int CW = cnt_width(SIZE);
  localparam logic [CW-1:0] CNT_LAST = CW'(3 * SIZE - 3);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          en;

  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] a_reg, b_reg;
  logic [SIZE-1:0][WIDTHx-1:0]           left_feed, top_feed;
  logic [SIZE-1:0][SIZE-1:0][WIDTHx-1:0] a_src, b_src, a_pass, b_pass;
  logic [SIZE-1:0][WIDTHx-1:0]           a_edge_unused, b_edge_unused;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == LOAD) begin
        a_reg <= a_input;
        b_reg <= b_input;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        if (cnt_q == CNT_LAST) state_d = DONE;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      default: begin
        state_d = DONE;
      end
    endcase
  end

  assign en   = (state_q == RUN);
  assign done = (state_q == DONE);

  // Row i / column i sees element k at step t = i + k, giving the diagonal skew.
  always_comb begin
    left_feed = '0;
    top_feed  = '0;
    if (state_q == RUN) begin
      for (int i = 0; i < SIZE; i++) begin
        for (int k = 0; k < SIZE; k++) begin
          if (int'(cnt_q) == i + k) begin
            left_feed[i] = a_reg[i][k];
            top_feed[i]  = b_reg[k][i];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < SIZE; i++) begin : g_row
    assign a_edge_unused[i] = a_pass[i][SIZE-1];
    assign b_edge_unused[i] = b_pass[SIZE-1][i];
    for (genvar j = 0; j < SIZE; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_src[i][j] = left_feed[i];
      end else begin : g_a_inner
        assign a_src[i][j] = a_pass[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_src[i][j] = top_feed[j];
      end else begin : g_b_inner
        assign b_src[i][j] = b_pass[i-1][j];
      end

      mult_celula #(
        .WIDTH (WIDTH),
        .WIDTHx(WIDTHx)
      ) u_cell (
        .clock (clock),
        .nreset(nreset),
        .en    (en),
        .a_in  (a_src[i][j]),
        .b_in  (b_src[i][j]),
        .a_out (a_pass[i][j]),
        .b_out (b_pass[i][j]),
        .acc   (output_produc_a_b[i][j])
      );
    end
  end

endmodule

// File: tb/tb_top_mult_celula_sa.sv
// Directed bench for top_mult_celula_sa: a 16-bit 5x5 instance plus an 8-bit wrap/saturate instance.
module tb_top_mult_celula_sa;

  typedef logic [4:0][4:0][4:0] mat_t;

  logic clock = 1'b0;
  logic nreset = 1'b0;
  mat_t a_in, b_in, a31;
  mat_t seqm, identm, sevens;
  logic [4:0][4:0][15:0] c_out;
  logic [4:0][4:0][7:0]  c8;
  logic done0, done1;
  int total = 0;
  int bad = 0;
  int edges;
  logic [31:0] exp8;

  always #5 clock = ~clock;

  top_mult_celula_sa #(.WIDTH(16), .WIDTHx(5), .SIZE(5)) dut (
    .clock(clock), .nreset(nreset), .a_input(a_in), .b_input(b_in),
    .output_produc_a_b(c_out), .done(done0)
  );

  top_mult_celula_sa #(.WIDTH(8), .WIDTHx(5), .SIZE(5)) dut8 (
    .clock(clock), .nreset(nreset), .a_input(a31), .b_input(a31),
    .output_produc_a_b(c8), .done(done1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input mat_t a, input mat_t b);
    a_in = a;
    b_in = b;
  endtask

  function automatic logic [31:0] refElem(input mat_t a, input mat_t b, input int i, input int j);
    int s = 0;
    for (int k = 0; k < 5; k++) s += int'(a[i][k]) * int'(b[k][j]);
    return 32'(s[15:0]);
  endfunction

  function automatic int nonzeroCount();
    int n = 0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        if (c_out[i][j] !== 16'd0) n++;
        if (c8[i][j] !== 8'd0) n++;
      end
    return n;
  endfunction

  task automatic checkMatrix(input string tag, input mat_t a, input mat_t b);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        checkOutput($sformatf("%s_c%0d%0d", tag, i, j), 32'(c_out[i][j]), refElem(a, b, i, j));
  endtask

  task automatic runToDone(output int n);
    n = 0;
    while (done0 !== 1'b1 && n < 30) begin
      @(posedge clock);
      #1;
      n++;
    end
  endtask

  task automatic restart(input mat_t a, input mat_t b);
    @(negedge clock);
    nreset = 1'b0;
    applyStimulus(a, b);
    @(negedge clock);
    nreset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        seqm[i][j]   = 5'(i * 5 + j + 1);
        identm[i][j] = (i == j) ? 5'd1 : 5'd0;
        sevens[i][j] = 5'd7;
      end
    a31 = '1;
`ifdef TOP_MULT_SAT_EN
    exp8 = 32'd255;
`else
    exp8 = 32'd197;
`endif

    // Reset held for three edges
    nreset = 1'b0;
    applyStimulus(seqm, seqm);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_nonzero", 32'(nonzeroCount()), 32'd0);
    checkOutput("rst_done", 32'(done0), 32'd0);

    // A = B = 1..25
    nreset = 1'b1;
    runToDone(edges);
    checkOutput("seq_edges", 32'(edges), 32'd14);
    checkOutput("seq_done", 32'(done0), 32'd1);
    checkOutput("seq_c00", 32'(c_out[0][0]), 32'd215);
    checkOutput("seq_c04", 32'(c_out[0][4]), 32'd275);
    checkOutput("seq_c40", 32'(c_out[4][0]), 32'd1315);
    checkOutput("seq_c44", 32'(c_out[4][4]), 32'd1775);
    checkMatrix("seq", seqm, seqm);
    checkOutput("w8_done", 32'(done1), 32'd1);
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        checkOutput($sformatf("w8_c%0d%0d", i, j), 32'(c8[i][j]), exp8);

    // Identity times B, then hold after done
    restart(identm, seqm);
    runToDone(edges);
    checkOutput("ident_edges", 32'(edges), 32'd14);
    checkMatrix("ident", identm, seqm);
    repeat (5) @(posedge clock);
    #1;
    checkMatrix("ident_hold", identm, seqm);
    checkOutput("ident_hold_done", 32'(done0), 32'd1);

    // Inputs changed during RUN must be ignored
    restart(seqm, seqm);
    repeat (4) @(posedge clock);
    @(negedge clock);
    applyStimulus(sevens, identm);
    runToDone(edges);
    checkOutput("chg_edges", 32'(edges), 32'd10);
    checkMatrix("chg", seqm, seqm);

    // Asynchronous reset in the middle of RUN
    restart(seqm, seqm);
    repeat (7) @(posedge clock);
    #1;
    checkOutput("mid_partial", 32'(nonzeroCount() > 0), 32'd1);
    #1;
    nreset = 1'b0;
    #1;
    checkOutput("mid_rst_nonzero", 32'(nonzeroCount()), 32'd0);
    checkOutput("mid_rst_done", 32'(done0), 32'd0);
    @(negedge clock);
    @(negedge clock);
    nreset = 1'b1;
    runToDone(edges);
    checkOutput("mid_edges", 32'(edges), 32'd14);
    checkMatrix("mid", seqm, seqm);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
